// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_arbiter block: FSM encoding, grant IDs and
// default parameters. Optional round-robin arbitration is enabled by MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  localparam int TIMEOUT_CYCLES_DEF = 16;
  localparam int TO_W_DEF           = 8;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_wdog.sv
// Bus watchdog: counts BUSY cycles since the last grant and flags the cycle in
// which the transaction has used up its full TIMEOUT_CYCLES budget.
module mem_arb_wdog #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // High during the last allowed BUSY cycle; the FSM aborts on this edge.
  assign expired = enable && (count == LAST);

endmodule : mem_arb_wdog

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory with a bus
// watchdog. Define MEM_ARB_RR_EN for round-robin on simultaneous requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TO_W           = TO_W_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic [31:0] i_rdata_out,
  output logic        i_ack_out,
  input  logic        d_req_in,
  input  logic        d_wr_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_mask_in,
  output logic [31:0] d_rdata_out,
  output logic        d_ack_out,
  output logic        mem_req_out,
  output logic        mem_wr_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_mask_out,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_ack_in,
  output logic        stall_out,
  output logic        bus_err_out
);

  state_t state;
  logic   i_elig;
  logic   d_elig;
  logic   grant_i;
  logic   grant_d;
  logic   busy;
  logic   expired;

`ifdef MEM_ARB_RR_EN
  gnt_t   rr_ptr;  // port that wins the next contested grant
`endif

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    i_elig  = i_req_in & ~i_ack_out;
    d_elig  = d_req_in & ~d_ack_out;
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
`ifdef MEM_ARB_RR_EN
      grant_d = d_elig & (~i_elig | (rr_ptr == GNT_D));
`else
      grant_d = d_elig;
`endif
      grant_i = i_elig & ~grant_d;
    end
  end

  assign busy      = (state != IDLE);
  assign stall_out = (i_req_in & ~i_ack_out) | (d_req_in & ~d_ack_out);

  mem_arb_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_wdog (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear   (grant_i | grant_d),
    .enable  (busy),
    .expired (expired)
  );

  // NOTE: reset clears every output register so nothing stale from an aborted
  // transaction is visible to the core or the memory afterwards.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      mem_req_out   <= 1'b0;
      mem_wr_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_mask_out  <= '0;
      i_ack_out     <= 1'b0;
      d_ack_out     <= 1'b0;
      i_rdata_out   <= '0;
      d_rdata_out   <= '0;
      bus_err_out   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_ptr        <= GNT_D;
`endif
    end else begin
      i_ack_out   <= 1'b0;
      d_ack_out   <= 1'b0;
      bus_err_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state         <= D_BUSY;
            mem_req_out   <= 1'b1;
            mem_wr_out    <= d_wr_in;
            mem_addr_out  <= d_addr_in;
            mem_wdata_out <= d_wdata_in;
            mem_mask_out  <= d_mask_in;
          end else if (grant_i) begin
            state         <= I_BUSY;
            mem_req_out   <= 1'b1;
            mem_wr_out    <= 1'b0;
            mem_addr_out  <= i_addr_in;
            mem_wdata_out <= '0;
            mem_mask_out  <= 4'hF;
          end
`ifdef MEM_ARB_RR_EN
          // Only a contested grant moves the pointer.
          if (i_elig && d_elig) begin
            rr_ptr <= grant_d ? GNT_I : GNT_D;
          end
`endif
        end
        I_BUSY, D_BUSY: begin
          // A real completion wins over a coincident watchdog expiry.
          if (mem_ack_in) begin
            state       <= IDLE;
            mem_req_out <= 1'b0;
            if (state == D_BUSY) begin
              d_rdata_out <= mem_rdata_in;
              d_ack_out   <= 1'b1;
            end else begin
              i_rdata_out <= mem_rdata_in;
              i_ack_out   <= 1'b1;
            end
          end else if (expired) begin
            state       <= IDLE;
            mem_req_out <= 1'b0;
            bus_err_out <= 1'b1;
            if (state == D_BUSY) begin
              d_rdata_out <= '0;
              d_ack_out   <= 1'b1;
            end else begin
              i_rdata_out <= '0;
              i_ack_out   <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          mem_req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule : mem_arbiter
